// File: rtl/id_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_operand_stage_pkg
//  Description : Shared defaults, constants and the forwarding-select
//                encoding for the decode-side operand stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_operand_stage_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

    // Register r0 is hardwired to zero and never forwarded.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_GPR  = 3'd4
    } fwd_sel_e;

endpackage : id_operand_stage_pkg
`default_nettype wire

// File: rtl/id_operand_stage_forward_mux.sv
`default_nettype none
// ============================================================================
//  Module      : operand_forward_mux
//  Description : Resolves one source operand from r0, EX/MEM forwards, the
//                write-back bypass or the register-file read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_forward_mux
    import id_operand_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] i_idx,
    input  logic          i_ex_wreg,
    input  logic [AW-1:0] i_ex_rd,
    input  logic [DW-1:0] i_ex_data,
    input  logic          i_mem_wreg,
    input  logic [AW-1:0] i_mem_rd,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [DW-1:0] i_wb_wd,
    input  logic [DW-1:0] i_gpr_data,
    output logic [DW-1:0] o_operand
);

    fwd_sel_e w_sel;

    // Priority select: youngest producer wins; WB covers the write-at-edge
    // register file returning a stale value in the same cycle.
    always_comb begin
        w_sel = FWD_GPR;
        if (i_idx == REG_ZERO) begin
            w_sel = FWD_ZERO;
        end else if (i_ex_wreg && (i_ex_rd == i_idx)) begin
            w_sel = FWD_EX;
        end else if (i_mem_wreg && (i_mem_rd == i_idx)) begin
            w_sel = FWD_MEM;
        end else if (i_wb_we && (i_wb_rd == i_idx)) begin
            w_sel = FWD_WB;
        end
    end

    // Operand data steering from the decoded select.
    always_comb begin
        o_operand = i_gpr_data;
        case (w_sel)
            FWD_ZERO: o_operand = '0;
            FWD_EX:   o_operand = i_ex_data;
            FWD_MEM:  o_operand = i_mem_data;
            FWD_WB:   o_operand = i_wb_wd;
            default:  o_operand = i_gpr_data;
        endcase
    end

endmodule : operand_forward_mux
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_operand_stage
//  Description : Decode operand stage: register-file addressing, bypass and
//                forwarding, load-use hazard detection and ID/EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_dest,
    input  logic             id_wreg,
    input  logic             id_is_load,
    input  logic [DW-1:0]    id_imm,
    output logic [AW-1:0]    gpr_rs,
    output logic [AW-1:0]    gpr_rt,
    input  logic [DW-1:0]    gpr_rd1,
    input  logic [DW-1:0]    gpr_rd2,
    input  logic             ex_fwd_wreg,
    input  logic [AW-1:0]    ex_fwd_rd,
    input  logic [DW-1:0]    ex_fwd_data,
    input  logic             mem_fwd_wreg,
    input  logic [AW-1:0]    mem_fwd_rd,
    input  logic [DW-1:0]    mem_fwd_data,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_wd,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             ifid_stall,
    output logic             idex_valid,
    output logic [DW-1:0]    idex_a,
    output logic [DW-1:0]    idex_b,
    output logic [DW-1:0]    idex_imm,
    output logic [AW-1:0]    idex_dest,
    output logic             idex_wreg,
    output logic             idex_is_load,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DW-1:0]    w_a;
    logic [DW-1:0]    w_b;
    logic             w_load_use;

    logic             r_valid;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [DW-1:0]    r_imm;
    logic [AW-1:0]    r_dest;
    logic             r_wreg;
    logic             r_is_load;
    logic [CNT_W-1:0] r_stall_count;

    assign gpr_rs = id_rs;
    assign gpr_rt = id_rt;

    operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .i_idx      (id_rs),
        .i_ex_wreg  (ex_fwd_wreg),
        .i_ex_rd    (ex_fwd_rd),
        .i_ex_data  (ex_fwd_data),
        .i_mem_wreg (mem_fwd_wreg),
        .i_mem_rd   (mem_fwd_rd),
        .i_mem_data (mem_fwd_data),
        .i_wb_we    (wb_we),
        .i_wb_rd    (wb_rd),
        .i_wb_wd    (wb_wd),
        .i_gpr_data (gpr_rd1),
        .o_operand  (w_a)
    );

    operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .i_idx      (id_rt),
        .i_ex_wreg  (ex_fwd_wreg),
        .i_ex_rd    (ex_fwd_rd),
        .i_ex_data  (ex_fwd_data),
        .i_mem_wreg (mem_fwd_wreg),
        .i_mem_rd   (mem_fwd_rd),
        .i_mem_data (mem_fwd_data),
        .i_wb_we    (wb_we),
        .i_wb_rd    (wb_rd),
        .i_wb_wd    (wb_wd),
        .i_gpr_data (gpr_rd2),
        .o_operand  (w_b)
    );

    // A load in EX cannot forward its data yet; the consumer must wait a cycle.
    always_comb begin
        w_load_use = r_valid && r_is_load && (r_dest != REG_ZERO) && id_valid &&
                     ((id_use_rs && (id_rs == r_dest)) ||
                      (id_use_rt && (id_rt == r_dest)));
    end

    assign ifid_stall = !flush && (ex_hold || w_load_use);

    // ID/EX register: reset > flush > hold > load-use bubble > normal latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_imm         <= '0;
            r_dest        <= '0;
            r_wreg        <= 1'b0;
            r_is_load     <= 1'b0;
            r_stall_count <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ex_hold) begin
            // Downstream is stalled: every field keeps its value.
            r_valid <= r_valid;
        end else if (w_load_use) begin
            r_valid   <= 1'b0;
            r_wreg    <= 1'b0;
            r_is_load <= 1'b0;
            if (r_stall_count != {CNT_W{1'b1}}) begin
                r_stall_count <= r_stall_count + c_CNT_ONE;
            end
        end else begin
            r_valid   <= id_valid;
            r_a       <= w_a;
            r_b       <= w_b;
            r_imm     <= id_imm;
            r_dest    <= id_dest;
            r_wreg    <= id_wreg && id_valid;
            r_is_load <= id_is_load && id_valid;
        end
    end

    assign idex_valid   = r_valid;
    assign idex_a       = r_a;
    assign idex_b       = r_b;
    assign idex_imm     = r_imm;
    assign idex_dest    = r_dest;
    assign idex_wreg    = r_wreg;
    assign idex_is_load = r_is_load;
    assign stall_count  = r_stall_count;

endmodule : id_operand_stage
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_operand_stage
//  Description : Directed scoreboard bench for id_operand_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_is_load;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_imm;
    logic [4:0]  gpr_rs, gpr_rt;
    logic [31:0] gpr_rd1, gpr_rd2;
    logic        ex_fwd_wreg, mem_fwd_wreg, wb_we;
    logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_rd;
    logic [31:0] ex_fwd_data, mem_fwd_data, wb_wd;
    logic        flush, ex_hold;
    logic        ifid_stall, idex_valid, idex_wreg, idex_is_load;
    logic [31:0] idex_a, idex_b, idex_imm;
    logic [4:0]  idex_dest;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    // mode 0: valid+count, 1: +wreg/load flags, 2: every field
    typedef struct {
        int          id;
        int          mode;
        logic        v;
        logic [31:0] a, b, imm;
        logic [4:0]  dest;
        logic        wreg, ld;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    id_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_wreg(id_wreg), .id_is_load(id_is_load), .id_imm(id_imm),
        .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .gpr_rd1(gpr_rd1), .gpr_rd2(gpr_rd2),
        .ex_fwd_wreg(ex_fwd_wreg), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_wreg(mem_fwd_wreg), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .flush(flush), .ex_hold(ex_hold), .ifid_stall(ifid_stall),
        .idex_valid(idex_valid), .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm),
        .idex_dest(idex_dest), .idex_wreg(idex_wreg), .idex_is_load(idex_is_load),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL step %0d %s: got %h, expected %h", id, nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int mode, input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] dest, input logic wreg,
                                input logic ld, input logic [15:0] cnt);
        exp_t e;
        e.id = 0; e.mode = mode; e.v = v; e.a = a; e.b = b; e.imm = imm;
        e.dest = dest; e.wreg = wreg; e.ld = ld; e.cnt = cnt;
        return e;
    endfunction

    task automatic clr();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wreg = 0; id_is_load = 0;
        id_rs = 0; id_rt = 0; id_dest = 0; id_imm = 0;
        gpr_rd1 = 0; gpr_rd2 = 0;
        ex_fwd_wreg = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
        mem_fwd_wreg = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_we = 0; wb_rd = 0; wb_wd = 0;
        flush = 0; ex_hold = 0;
    endtask

    // Called at a negedge with inputs applied: checks the combinational stall,
    // queues the state expected after the coming edge, then moves to the next negedge.
    task automatic step(input int id, input exp_t e, input logic exp_stall);
        #1;
        chk(id, "ifid_stall", {31'd0, ifid_stall}, {31'd0, exp_stall});
        e.id = id;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, compare the registered outputs with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            chk(m_e.id, "idex_valid", {31'd0, idex_valid}, {31'd0, m_e.v});
            chk(m_e.id, "stall_count", {16'd0, stall_count}, {16'd0, m_e.cnt});
            if (m_e.mode >= 1) begin
                chk(m_e.id, "idex_wreg", {31'd0, idex_wreg}, {31'd0, m_e.wreg});
                chk(m_e.id, "idex_is_load", {31'd0, idex_is_load}, {31'd0, m_e.ld});
            end
            if (m_e.mode >= 2) begin
                chk(m_e.id, "idex_a", idex_a, m_e.a);
                chk(m_e.id, "idex_b", idex_b, m_e.b);
                chk(m_e.id, "idex_imm", idex_imm, m_e.imm);
                chk(m_e.id, "idex_dest", {27'd0, idex_dest}, {27'd0, m_e.dest});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1;
        repeat (2) @(negedge clk);

        // 1: reset state
        step(1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        rst = 0;

        // 2: write-through bypass on rs, rt from register file
        clr(); id_valid = 1; id_rs = 5; id_use_rs = 1; id_rt = 9; id_use_rt = 1;
        wb_we = 1; wb_rd = 5; wb_wd = 32'hDEADBEEF; gpr_rd1 = 0; gpr_rd2 = 32'h1234;
        id_imm = 32'h10; id_dest = 2; id_wreg = 1;
        step(2, mk(2, 1, 32'hDEADBEEF, 32'h1234, 32'h10, 2, 1, 0, 0), 0);

        // 3-6: forward priority on rt: EX > MEM > WB > GPR
        clr(); id_valid = 1; id_rs = 4; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
        gpr_rd1 = 32'hAAAA; gpr_rd2 = 32'h44; id_dest = 6; id_wreg = 1; id_imm = 32'hFFFF_FFF0;
        ex_fwd_wreg = 1; ex_fwd_rd = 3; ex_fwd_data = 32'h11;
        mem_fwd_wreg = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h22;
        wb_we = 1; wb_rd = 3; wb_wd = 32'h33;
        step(3, mk(2, 1, 32'hAAAA, 32'h11, 32'hFFFF_FFF0, 6, 1, 0, 0), 0);
        ex_fwd_wreg = 0;
        step(4, mk(2, 1, 32'hAAAA, 32'h22, 32'hFFFF_FFF0, 6, 1, 0, 0), 0);
        mem_fwd_wreg = 0;
        step(5, mk(2, 1, 32'hAAAA, 32'h33, 32'hFFFF_FFF0, 6, 1, 0, 0), 0);
        wb_we = 0;
        step(6, mk(2, 1, 32'hAAAA, 32'h44, 32'hFFFF_FFF0, 6, 1, 0, 0), 0);

        // 7: r0 is never forwarded
        clr(); id_valid = 1; id_rs = 0; id_rt = 0; id_use_rs = 1; id_use_rt = 1;
        gpr_rd1 = 32'h55; gpr_rd2 = 32'h66;
        ex_fwd_wreg = 1; mem_fwd_wreg = 1; wb_we = 1;
        ex_fwd_data = 32'hFFFFFFFF; mem_fwd_data = 32'hFFFFFFFF; wb_wd = 32'hFFFFFFFF;
        step(7, mk(2, 1, 0, 0, 0, 0, 0, 0, 0), 0);

        // 8: load to r7
        clr(); id_valid = 1; id_is_load = 1; id_wreg = 1; id_dest = 7; id_rs = 1; id_use_rs = 1;
        gpr_rd1 = 32'h1; id_imm = 32'h8;
        step(8, mk(2, 1, 32'h1, 0, 32'h8, 7, 1, 1, 0), 0);

        // 9: consumer of r7 right behind the load -> one bubble
        clr(); id_valid = 1; id_rs = 7; id_use_rs = 1; id_dest = 8; id_wreg = 1; gpr_rd1 = 32'h0BAD;
        step(9, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 1);

        // 10: load now in MEM, forward supplies the data
        mem_fwd_wreg = 1; mem_fwd_rd = 7; mem_fwd_data = 32'hCAFE;
        step(10, mk(2, 1, 32'hCAFE, 0, 0, 8, 1, 0, 1), 0);

        // 11: flush and hold together -> flush wins, no stall
        clr(); id_valid = 1; id_rs = 2; id_dest = 3; id_wreg = 1; flush = 1; ex_hold = 1;
        step(11, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0);

        // 12: fill the register with a known instruction
        clr(); id_valid = 1; id_rs = 2; id_use_rs = 1; gpr_rd1 = 32'h77; id_imm = 32'h99; id_dest = 4; id_wreg = 1;
        step(12, mk(2, 1, 32'h77, 0, 32'h99, 4, 1, 0, 1), 0);

        // 13-15: hold for three cycles with changing decode inputs
        for (int i = 0; i < 3; i++) begin
            clr(); ex_hold = 1; id_valid = 1; id_rs = 6; id_use_rs = 1;
            gpr_rd1 = 32'h123 + i; id_imm = i; id_dest = 5 + i; id_wreg = 1;
            step(13 + i, mk(2, 1, 32'h77, 0, 32'h99, 4, 1, 0, 1), 1);
        end

        // 16: load to r9
        clr(); id_valid = 1; id_is_load = 1; id_wreg = 1; id_dest = 9; id_rs = 3; id_use_rs = 1; gpr_rd1 = 32'h3;
        step(16, mk(2, 1, 32'h3, 0, 0, 9, 1, 1, 1), 0);

        // 17: consumer of r9 on rt while downstream holds -> hold wins, count unchanged
        clr(); id_valid = 1; id_rt = 9; id_use_rt = 1; id_dest = 10; id_wreg = 1; ex_hold = 1;
        step(17, mk(2, 1, 32'h3, 0, 0, 9, 1, 1, 1), 1);

        // 18: hold released -> load-use bubble, count 2
        ex_hold = 0;
        step(18, mk(1, 0, 0, 0, 0, 0, 0, 0, 2), 1);

        // 19: load to r10
        clr(); id_valid = 1; id_is_load = 1; id_wreg = 1; id_dest = 10; id_rs = 1; id_use_rs = 1; gpr_rd1 = 32'h4;
        step(19, mk(2, 1, 32'h4, 0, 0, 10, 1, 1, 2), 0);

        // 20: reset during a load-use stall
        clr(); id_valid = 1; id_rs = 10; id_use_rs = 1; id_dest = 11; id_wreg = 1; gpr_rd1 = 32'h5; rst = 1;
        step(20, mk(2, 0, 0, 0, 0, 0, 0, 0, 0), 1);

        // 21: after reset the same consumer proceeds
        rst = 0;
        step(21, mk(2, 1, 32'h5, 0, 0, 11, 1, 0, 0), 0);

        clr();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_id_operand_stage
`default_nettype wire
